// File: rtl/gated_delay_pipe_pkg.sv
// gated_delay_pkg: shared helpers and idle-mode constants for the gated delay pipe.
//  occ_width(depth) : width needed to count 0..depth valid stages
//  MODE_HOLD/ZERO   : values of the ZERO_ON_IDLE parameter
package gated_delay_pkg;
  localparam int MODE_HOLD = 0;
  localparam int MODE_ZERO = 1;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/gated_delay_pipe_if.sv
// gated_delay_pipe_if: bundles the lane data/control signals of the gated delay pipe.
//  flush     : synchronous clear of all lanes
//  ct        : per-lane force-advance control
//  in_data   : packed lane inputs, lane i at [i*WIDTH +: WIDTH]
//  out_data  : registered last stage + INC, same packing
//  out_valid : registered valid of the last stage per lane
//  occ       : per-lane count of valid stages, OW bits each
//  master drives flush/ct/in_data; slave (the pipe) drives the outputs.
interface gated_delay_pipe_if
  import gated_delay_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int LANES = 1
) ();
  localparam int OW = occ_width(DEPTH);
  logic                   flush;
  logic [LANES-1:0]       ct;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES*OW-1:0]    occ;
  modport master (output flush, ct, in_data, input out_data, out_valid, occ);
  modport slave  (input flush, ct, in_data, output out_data, out_valid, occ);
endinterface

// File: rtl/gated_delay_pipe_lane.sv
// gated_delay_lane: one lane of the gated delay line with its output increment stage.
//  clk, rst_n : clock, asynchronous active-low reset
//  flush      : clears stages and valids
//  ct         : force-advance control
//  in_data    : lane input sample
//  out_data   : registered last stage + INC
//  out_valid  : registered last-stage valid
//  occ        : popcount of stage valids
module gated_delay_lane
  import gated_delay_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 2,
  parameter int INC          = 1,
  parameter int ZERO_ON_IDLE = MODE_ZERO,
  parameter int OW           = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ct,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [OW-1:0]    occ
);
  logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d, s_idle;
  logic [DEPTH:0][WIDTH-1:0]   s_ext;
  logic [DEPTH-1:0]            v_q, v_d, v_idle;
  logic [DEPTH:0]              v_ext;
  logic [WIDTH-1:0]            out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        adv;
  assign adv   = ct | (|in_data);
  // Appending the new sample below the stages and dropping the top gives the shift for any DEPTH >= 1.
  assign s_ext = {s_q, in_data};
  assign v_ext = {v_q, 1'b1};
  always_comb begin
    s_idle = s_q;
    v_idle = v_q;
    if (ZERO_ON_IDLE == MODE_ZERO) begin
      s_idle[DEPTH-1] = '0;
      v_idle[DEPTH-1] = 1'b0;
    end
    s_d         = flush ? '0 : adv ? s_ext[DEPTH-1:0] : s_idle;
    v_d         = flush ? '0 : adv ? v_ext[DEPTH-1:0] : v_idle;
    out_data_d  = s_q[DEPTH-1] + WIDTH'(INC);
    out_valid_d = v_q[DEPTH-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      v_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      v_q         <= v_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign occ       = OW'($countones(v_q));
endmodule

// File: rtl/gated_delay_pipe.sv
// gated_delay_pipe: multi-lane gated delay line with registered +INC output stage.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : slave side of gated_delay_pipe_if (flush, ct, in_data in; out_data, out_valid, occ out)
//  Each lane is an independent gated_delay_lane; this level only packs and unpacks.
module gated_delay_pipe
  import gated_delay_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 2,
  parameter int LANES        = 1,
  parameter int INC          = 1,
  parameter int ZERO_ON_IDLE = MODE_ZERO
) (
  input logic              clk,
  input logic              rst_n,
  gated_delay_pipe_if.slave bus
);
  localparam int OW = occ_width(DEPTH);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gated_delay_lane #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .INC(INC), .ZERO_ON_IDLE(ZERO_ON_IDLE), .OW(OW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush),
      .ct       (bus.ct[i]),
      .in_data  (bus.in_data[i*WIDTH +: WIDTH]),
      .out_data (bus.out_data[i*WIDTH +: WIDTH]),
      .out_valid(bus.out_valid[i]),
      .occ      (bus.occ[i*OW +: OW])
    );
  end
endmodule
